// File: rtl/turn_controller.sv
// Turn sequencer for a card-matching game: select, compare, move, win check, pass turn.
// Latency: select accepted -> A next cycle; go sampled one cycle after A; B then W one cycle apart.
// Backpressure: none; sel_valid and start are dropped unless the FSM is in a state that takes them.
module turn_controller #(
  parameter int NUM_CARDS      = 12,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] N,
  input  logic       sel_valid,
  input  logic [3:0] card_sel,
  input  logic       go,
  input  logic       W,
  output logic [3:0] position_data,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic [1:0] cur_player,
  output logic [3:0] streak,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_CHECK  = 3'd2,
    S_JUDGE  = 3'd3,
    S_MOVE   = 3'd4,
    S_WINCHK = 3'd5,
    S_NEXT   = 3'd6,
    S_OVER   = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      n_q, n_d;
  logic [1:0]      cur_player_q, cur_player_d;
  logic [3:0]      streak_q, streak_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      position_data_q, position_data_d;
  logic [1:0]      winner_q, winner_d;

  logic card_ok;
  logic sel_accept;
  logic timed_out;

  assign card_ok    = 32'(card_sel) < NUM_CARDS;
  assign sel_accept = (state_q == S_SELECT) && sel_valid && card_ok;
  assign timed_out  = (timer_q == TIMER_LAST);

  // State register; reset aborts whatever turn is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accepted selection takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_SELECT;
      S_SELECT: begin
        if (sel_accept)     state_d = S_CHECK;
        else if (timed_out) state_d = S_NEXT;
      end
      S_CHECK:  state_d = S_JUDGE;
      S_JUDGE:  state_d = go ? S_MOVE : S_NEXT;
      S_MOVE:   state_d = S_WINCHK;
      S_WINCHK: state_d = W ? S_OVER : S_SELECT;
      S_NEXT:   state_d = S_SELECT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore strobes decoded straight from the state register.
  always_comb begin
    A                    = (state_q == S_CHECK);
    B                    = (state_q == S_MOVE);
    statecombo_next_turn = (state_q == S_NEXT);
    game_over            = (state_q == S_OVER);
  end

  // Game bookkeeping: player rotation, streak, select timer, card and winner registers.
  always_comb begin
    n_d             = n_q;
    cur_player_d    = cur_player_q;
    streak_d        = streak_q;
    timer_d         = timer_q;
    position_data_d = position_data_q;
    winner_d        = winner_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          n_d          = N;
          cur_player_d = 2'd0;
          streak_d     = 4'd0;
          timer_d      = '0;
          winner_d     = 2'd0;
        end
      end
      S_SELECT: begin
        if (sel_accept) begin
          position_data_d = card_sel;
          timer_d         = '0;
        end else if (timed_out) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WINCHK: begin
        if (W) begin
          winner_d = cur_player_q;
        end else begin
          if (streak_q != 4'd15) streak_d = streak_q + 4'd1;
          timer_d = '0;
        end
      end
      S_NEXT: begin
        cur_player_d = (cur_player_q == n_q) ? 2'd0 : cur_player_q + 2'd1;
        streak_d     = 4'd0;
        timer_d      = '0;
      end
      default: ;
    endcase
  end

  // Bookkeeping registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q             <= 2'd0;
      cur_player_q    <= 2'd0;
      streak_q        <= 4'd0;
      timer_q         <= '0;
      position_data_q <= 4'd0;
      winner_q        <= 2'd0;
    end else begin
      n_q             <= n_d;
      cur_player_q    <= cur_player_d;
      streak_q        <= streak_d;
      timer_q         <= timer_d;
      position_data_q <= position_data_d;
      winner_q        <= winner_d;
    end
  end

  assign position_data = position_data_q;
  assign cur_player    = cur_player_q;
  assign streak        = streak_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] N;
  logic       sel_valid;
  logic [3:0] card_sel;
  logic       go;
  logic       W;
  logic [3:0] position_data;
  logic       A;
  logic       B;
  logic       nt;
  logic [1:0] cur_player;
  logic [3:0] streak;
  logic       game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  turn_controller #(.NUM_CARDS(12), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .sel_valid(sel_valid),
    .card_sel(card_sel), .go(go), .W(W), .position_data(position_data),
    .A(A), .B(B), .statecombo_next_turn(nt), .cur_player(cur_player),
    .streak(streak), .game_over(game_over), .winner(winner)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Game-level reference state
  int m_n, m_player, m_streak, m_pos, m_winner;
  bit m_over;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pos"}, position_data, 0);
    check_val({tag, "_A"}, A, 0);
    check_val({tag, "_B"}, B, 0);
    check_val({tag, "_nt"}, nt, 0);
    check_val({tag, "_player"}, cur_player, 0);
    check_val({tag, "_streak"}, streak, 0);
    check_val({tag, "_over"}, game_over, 0);
    check_val({tag, "_winner"}, winner, 0);
  endtask

  task automatic model_reset();
    m_n = 0; m_player = 0; m_streak = 0; m_pos = 0; m_winner = 0; m_over = 0;
  endtask

  task automatic pass_turn();
    m_player = (m_player == m_n) ? 0 : m_player + 1;
    m_streak = 0;
  endtask

  // Called at a negedge; leaves the bench at a negedge with the DUT idle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_rel");
  endtask

  // Leaves the bench at the negedge inside the first SELECT cycle.
  task automatic start_game(input int n);
    N = 2'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_n = n; m_player = 0; m_streak = 0; m_over = 0;
    check_val("start_player", cur_player, 0);
    check_val("start_streak", streak, 0);
    check_val("start_over", game_over, 0);
  endtask

  // One turn attempt: idle g cycles in SELECT, then offer card. g>=8 forfeits by timeout.
  task automatic pick(input int g, input int card, input bit gv, input bit wv);
    go = gv;
    W  = wv;
    N  = 2'($urandom);
    if (g >= 8) begin
      repeat (8) @(negedge clk);
      check_val("to_next", nt, 1);
      check_val("to_noA", A, 0);
      check_val("to_pos", position_data, m_pos);
      sel_valid = 1'b1;
      card_sel  = 4'(card);
      @(negedge clk);
      sel_valid = 1'b0;
      check_val("to_sel_dropped", A, 0);
      pass_turn();
    end else begin
      repeat (g) @(negedge clk);
      sel_valid = 1'b1;
      card_sel  = 4'(card);
      start     = 1'($urandom);
      @(negedge clk);
      sel_valid = 1'b0;
      start     = 1'b0;
      m_pos = card;
      check_val("chk_A", A, 1);
      check_val("chk_pos", position_data, card);
      @(negedge clk);
      check_val("judge_A", A, 0);
      check_val("judge_B", B, 0);
      @(negedge clk);
      if (gv) begin
        check_val("move_B", B, 1);
        check_val("move_nt", nt, 0);
        @(negedge clk);
        check_val("winchk_B", B, 0);
        @(negedge clk);
        if (wv) begin
          m_over = 1;
          m_winner = m_player;
        end else begin
          m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        end
      end else begin
        check_val("next_nt", nt, 1);
        check_val("next_B", B, 0);
        @(negedge clk);
        check_val("next_nt_once", nt, 0);
        pass_turn();
      end
    end
    check_val("player", cur_player, m_player);
    check_val("streak", streak, m_streak);
    check_val("game_over", game_over, int'(m_over));
    if (m_over) check_val("winner", winner, m_winner);
  endtask

  // In OVER: selections must be ignored and the result held.
  task automatic over_probe();
    for (int i = 0; i < 3; i++) begin
      sel_valid = 1'b1;
      card_sel  = 4'(i + 2);
      go = 1'b1;
      @(negedge clk);
      check_val("over_A", A, 0);
      check_val("over_B", B, 0);
      check_val("over_hold", game_over, 1);
      check_val("over_winner", winner, m_winner);
    end
    sel_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; N = 2'd0; sel_valid = 1'b0;
    card_sel = 4'd0; go = 1'b0; W = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Basic turn pass, two players
    do_reset();
    start_game(1);
    pick(0, 5, 1'b0, 1'b0);

    // Three players, three misses: 1,2,0
    do_reset();
    start_game(2);
    for (int i = 0; i < 3; i++) pick(1, 3 + i, 1'b0, 1'b0);

    // Streak saturation over 16 correct picks
    do_reset();
    start_game(3);
    for (int i = 0; i < 16; i++) pick(int'($urandom_range(0, 3)), int'($urandom_range(0, 11)), 1'b1, 1'b0);
    check_val("streak_sat", streak, 15);

    // Player 1 wins, then restart from OVER with a single player
    do_reset();
    start_game(1);
    pick(0, 4, 1'b0, 1'b0);
    pick(1, 6, 1'b1, 1'b1);
    over_probe();
    start_game(0);
    pick(0, 1, 1'b0, 1'b0);
    pick(2, 2, 1'b0, 1'b0);

    // Out-of-range card ignored, timer keeps running into a timeout
    do_reset();
    start_game(2);
    sel_valid = 1'b1;
    card_sel  = 4'd13;
    @(negedge clk);
    sel_valid = 1'b0;
    check_val("bad_card_A", A, 0);
    repeat (6) @(negedge clk);
    check_val("bad_card_nt_early", nt, 0);
    @(negedge clk);
    check_val("bad_card_timeout", nt, 1);
    @(negedge clk);
    pass_turn();
    check_val("bad_card_player", cur_player, m_player);
    // Selection in the last SELECT cycle beats the timeout
    pick(7, 9, 1'b0, 1'b0);
    pick(8, 2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of MOVE
    do_reset();
    start_game(1);
    go = 1'b1;
    W  = 1'b0;
    sel_valid = 1'b1;
    card_sel  = 4'd3;
    @(negedge clk);
    sel_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_B", B, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_move");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      sel_valid = 1'b1;
      card_sel  = 4'd3;
      @(negedge clk);
      check_val("post_rst_A", A, 0);
      check_val("post_rst_B", B, 0);
    end
    sel_valid = 1'b0;

    // Randomized games
    start_game(int'($urandom_range(0, 3)));
    for (int i = 0; i < 200; i++) begin
      if (m_over) begin
        over_probe();
        start_game(int'($urandom_range(0, 3)));
      end else begin
        pick(($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(0, 7)),
             int'($urandom_range(0, 11)),
             1'($urandom),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
